// File: rtl/mem_sequencer.sv
// Ping-pong sequencer for a two-block memory: fills blk1 then blk2 from the input stream
// and drains each full block in address order, one block access per cycle.
module mem_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        memoryena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        r_full;
  logic              r_wbank;
  logic              r_rbank;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_rd_pending;
  logic              r_last_pending;
  logic              r_prio;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_last;
  logic              r_out_valid;

  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_wr_grant;
  logic              w_rd_grant;
  logic              w_contested;
  logic              w_wr_wrap;
  logic              w_rd_wrap;
  logic [1:0]        w_full_next;

  // Grants are gated by rst so the memory sees a harmless idle read while in reset.
  always_comb begin
    w_wr_elig   = !rst && in_valid && !r_full[r_wbank];
    w_rd_elig   = !rst && r_full[r_rbank] && !r_rd_pending && (!r_out_valid || out_ready);
    w_contested = w_wr_elig && w_rd_elig;
    w_rd_grant  = w_rd_elig && (!w_wr_elig || r_prio);
    w_wr_grant  = w_wr_elig && !w_rd_grant;
    w_wr_wrap   = (r_waddr == LAST_ADDR);
    w_rd_wrap   = (r_raddr == LAST_ADDR);
    in_ready    = !rst && !r_full[r_wbank] && !w_rd_grant;

    memoryena = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_wr_grant) begin
      memoryena = {r_wbank, 1'b1};
      mem_addr  = r_waddr;
      mem_wdata = in_data;
    end else if (w_rd_grant) begin
      memoryena = {r_rbank, 1'b0};
      mem_addr  = r_raddr;
    end
  end

  // A bank is marked full by its last write and freed as soon as its last read issues.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_full
      assign w_full_next[gi] =
        (w_wr_grant && w_wr_wrap && (r_wbank == 1'(gi))) ? 1'b1 :
        (w_rd_grant && w_rd_wrap && (r_rbank == 1'(gi))) ? 1'b0 :
        r_full[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full         <= 2'b00;
      r_wbank        <= 1'b0;
      r_rbank        <= 1'b0;
      r_waddr        <= '0;
      r_raddr        <= '0;
      r_rd_pending   <= 1'b0;
      r_last_pending <= 1'b0;
      r_prio         <= 1'b0;
      r_out_data     <= '0;
      r_out_last     <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      r_full       <= w_full_next;
      r_rd_pending <= w_rd_grant;
      if (w_contested) begin
        r_prio <= ~r_prio;
      end
      if (w_wr_grant) begin
        r_waddr <= w_wr_wrap ? '0 : r_waddr + 1'b1;
        if (w_wr_wrap) begin
          r_wbank <= ~r_wbank;
        end
      end
      if (w_rd_grant) begin
        r_raddr        <= w_rd_wrap ? '0 : r_raddr + 1'b1;
        r_last_pending <= w_rd_wrap;
        if (w_rd_wrap) begin
          r_rbank <= ~r_rbank;
        end
      end
      // Capture wins over the handshake clear so a back-to-back word is never lost.
      if (r_rd_pending) begin
        r_out_data  <= mem_rdata;
        r_out_last  <= r_last_pending;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a two-block memory model holding registered read data.
`timescale 1ns/1ps
module tb_mem_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] memoryena;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem_blk [2][16];

  int n_checks = 0;
  int n_fail   = 0;

  mem_sequencer #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .memoryena (memoryena),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write on memoryena[0], registered read of the addressed block otherwise.
  always @(posedge clk) begin
    if (memoryena[0]) mem_blk[memoryena[1]][mem_addr] <= mem_wdata;
    mem_rdata <= mem_blk[memoryena[1]][mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int wi;
    int ri;
    int npat;
    logic [7:0] pat;
    logic found;

    // Reset values, sampled while rst is still high.
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step();
    step();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_memoryena", memoryena, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Fill blk1 with 0x00..0x0F, one write per cycle.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      chk("fill_in_ready", in_ready, 1);
      chk("fill_ena", memoryena, 2'b01);
      chk("fill_addr", mem_addr, i);
      chk("fill_wdata", mem_wdata, i);
      step();
    end
    in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rd0_ena", memoryena, 2'b00);
    chk("rd0_addr", mem_addr, 0);
    chk("rd0_in_ready", in_ready, 0);
    $display("fill blk1 done, first read issued");
    step();
    step();
    chk("rd0_out_valid", out_valid, 1);
    chk("rd0_out_data", out_data, 8'h00);

    // Drain blk1: one word every two cycles, last flag only on 0x0F.
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, k);
      chk("drain_last", out_last, (k == 15) ? 1 : 0);
      chk("drain_ena", memoryena, 2'b00);
      chk("drain_next_addr", mem_addr, (k < 15) ? k + 1 : 0);
      $display("drain word %0d data 0x%0h last %0d", k, out_data, out_last);
      step();
      chk("drain_gap", out_valid, 0);
      step();
    end
    out_ready = 1'b0;

    // Continuous stream of 48 words with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    wi = 0; ri = 0; npat = 0; pat = 8'h00;
    for (int cyc = 0; cyc < 600 && ri < 48; cyc++) begin
      in_valid = (wi < 48);
      in_data  = 8'(8'h40 + wi);
      #1;
      if (wi >= 16 && npat < 8) begin
        pat = {pat[6:0], in_ready};
        npat++;
      end
      if (in_valid && in_ready) begin
        chk("stream_wr_ena", memoryena, ((wi / 16) % 2) * 2 + 1);
        chk("stream_wr_addr", mem_addr, wi % 16);
        wi++;
      end
      if (out_valid) begin
        chk("stream_data", out_data, 8'(8'h40 + ri));
        chk("stream_last", out_last, (ri % 16 == 15) ? 1 : 0);
        $display("stream out %0d data 0x%0h", ri, out_data);
        ri++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("stream_done", ri, 48);
    chk("stream_written", wi, 48);
    chk("contend_pattern", pat, 8'b1011_0110);

    // Fill both banks with the consumer stalled, then drain blk1 until its last read.
    do_reset();
    wi = 0;
    for (int cyc = 0; cyc < 200 && wi < 32; cyc++) begin
      in_valid = 1'b1; in_data = 8'(8'h90 + wi);
      #1;
      if (in_ready) wi++;
      step();
    end
    chk("both_written", wi, 32);
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    chk("both_full_in_ready", in_ready, 0);
    step();
    chk("both_full_in_ready2", in_ready, 0);
    out_ready = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (memoryena == 2'b00 && mem_addr == 4'd15) begin
        chk("rd15_in_ready", in_ready, 0);
        found = 1'b1;
        step();
        break;
      end
      step();
    end
    chk("rd15_found", found, 1);
    #1;
    chk("refill_in_ready", in_ready, 1);
    chk("refill_ena", memoryena, 2'b01);
    chk("refill_addr", mem_addr, 0);
    $display("blk1 refill write accepted after last read");
    in_valid = 1'b0; out_ready = 1'b0;

    // Backpressure: the held word must stay put and no read may issue.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i);
      step();
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (out_valid) break;
      step();
    end
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h80);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h80);
      chk("bp_no_read", mem_addr, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_addr", mem_addr, 1);
    $display("backpressure released, read addr %0d", mem_addr);
    step();

    // Reset while the read of addr 1 is pending.
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_ena", memoryena, 2'b00);
    step();
    rst = 1'b0;
    #1;
    chk("postrst_out_valid", out_valid, 0);
    chk("postrst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("postrst_wr_ena", memoryena, 2'b01);
    chk("postrst_wr_addr", mem_addr, 0);
    step();
    in_valid = 1'b0;
    #1;
    chk("postrst_no_capture", out_valid, 0);
    $display("reset mid-drain: write restarted at blk1 addr 0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Access sequencer directly upstream of the two-block memory enable decoder. Accepts a word stream from the deserializer side and fills memory block 1, then block 2, alternately, DEPTH words per block. Drains each full block, in address order, to the serializer side. Drives the 2-bit `memoryena` code the decoder consumes, plus shared address and write data. Exactly one block access occurs per cycle.

## Interface
- WIDTH, 8, data word width
- DEPTH, 16, words per block (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), block address width
- clk  in  1  system clock, single clock domain
- rst  in  1  reset: synchronous, active-high
- in_data  in  WIDTH  write word
- in_valid  in  1  write word offered
- in_ready  out  1  write word accepted this cycle when in_valid&&in_ready
- out_data  out  WIDTH  read word (registered)
- out_last  out  1  out_data is the final word of its block
- out_valid  out  1  read word available
- out_ready  in  1  downstream consumes when out_valid&&out_ready
- memoryena  out  2  {bank, write}: 00 read blk1, 01 write blk1, 10 read blk2, 11 write blk2
- mem_addr  out  ADDR_W  shared block address
- mem_wdata  out  WIDTH  shared write data
- mem_rdata  in  WIDTH  block read data, valid one cycle after read issue

## Operation
- State:
  - full[1:0] per-bank flags
  - wbank, waddr: write bank and address
  - rbank, raddr: read bank and address
  - rd_pending: read issued last cycle
  - prio: 0 = write wins, 1 = read wins
- Write eligible: in_valid && !full[wbank].
- Read eligible: full[rbank] && !rd_pending && (!out_valid || out_ready).
- Grant:
  - Only one eligible: that one is granted.
  - Both eligible: prio decides; prio toggles after every contested grant.
- in_ready = !full[wbank] && !(read granted); combinational.
- Write grant:
  - memoryena={wbank,1}, mem_addr=waddr, mem_wdata=in_data.
  - waddr++.
  - On waddr==DEPTH-1: set full[wbank], waddr←0, wbank toggles.
- Read grant:
  - memoryena={rbank,0}, mem_addr=raddr; rd_pending←1.
  - raddr++.
  - On raddr==DEPTH-1: clear full[rbank] at issue, raddr←0, rbank toggles, pending last flag set.
- Read capture (cycle after issue):
  - out_data←mem_rdata, out_last←last flag, out_valid←1, rd_pending←0.
  - out_valid clears on handshake unless a capture occurs in the same cycle.
- No grant: memoryena=00, mem_addr=0, mem_wdata=0. This is a harmless read of block 1 with no state change.
- Both banks full: in_ready=0. Both banks empty: no reads issue; out_valid drains.
- Bank order is strictly blk1, blk2, blk1, … on both sides; words exit in the order they arrived.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_last=0, out_data=0
  - memoryena=00, mem_addr=0, mem_wdata=0
  - full=00, wbank=rbank=0, waddr=raddr=0, rd_pending=0, prio=0
- Reset mid-operation: the in-flight read is discarded, all banks are treated as empty, and pointers return to zero. Memory contents are not cleared.
- memoryena, mem_addr and mem_wdata are combinational from grant, in the same cycle as the accept.
- Read latency: issue at T → mem_rdata at T+1 → out_valid at T+2.
- Maximum read throughput is one word per 2 cycles (single outstanding read). A read may issue in the same cycle out_valid&&out_ready completes.
- Write throughput is one word per cycle when uncontested.
- A bank becomes writable again in the cycle after its last read issues.
- Writes to bank N and reads of the other bank interleave under prio alternation. Neither side starves.

## Test plan
- Reset then 16 writes 0x00..0x0F with out_ready=0:
  - memoryena=01 and mem_addr 0..15 on consecutive cycles.
  - full[0] set, wbank=1.
  - Read of block 1 at addr 0 issues next cycle.
- Drain block 1 with out_ready=1:
  - out_data sequence 0x00..0x0F, one word every 2 cycles.
  - out_last=1 only on 0x0F.
  - memoryena=00 on read cycles.
- Stream 48 words continuously with out_ready=1:
  - Banks alternate blk1, blk2, blk1; output order is identical to input.
  - During contention in_ready drops on alternate contested cycles only.
- Fill both banks (32 words), hold in_valid=1 → in_ready=0. After the first read of addr 15 of blk1 issues, in_ready=1 the next cycle with memoryena=01, addr 0.
- Backpressure: out_ready=0 for 10 cycles with out_valid=1 → out_data stable, no further read issues, raddr unchanged.
- Assert rst for 1 cycle mid-drain with rd_pending=1 → next cycle out_valid=0, in_ready=1, and the next write goes to blk1 at addr 0.
